// File: rtl/pgm_sound_mailbox_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : pgm_snd_pkg
//  Description : Shared width helpers and status bit positions for the
//                main-CPU / sound-CPU mailbox.
//  Revision    : 1.0  initial release
// ============================================================================
package pgm_snd_pkg;

    // Position of each flag inside a channel's 3-bit main-side status group
    localparam int OVF_BIT  = 2;
    localparam int FULL_BIT = 1;
    localparam int PEND_BIT = 0;

    // Channel-select width; a single channel still gets one select bit
    function automatic int calc_cw(input int channels);
        return (channels <= 2) ? 1 : $clog2(channels);
    endfunction

    // Occupancy counter width, must be able to hold the value DEPTH itself
    function automatic int calc_cntw(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Pointer width; DEPTH=1 still needs a one-bit pointer
    function automatic int calc_ptrw(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pgm_sound_mailbox_if.sv
`default_nettype none
// ============================================================================
//  Interface   : pgm_sound_mailbox_if
//  Description : Strobe/data bundle between the two CPU-side decoders and the
//                mailbox. master = decoder side, slave = mailbox.
//  Revision    : 1.0  initial release
// ============================================================================
interface pgm_sound_mailbox_if #(
    parameter int CHANNELS = 3,
    parameter int DW       = 8
);
    import pgm_snd_pkg::*;

    localparam int CW = calc_cw(CHANNELS);

    // Main (68k) side
    logic                    m_wr;
    logic                    m_rd;
    logic [CW-1:0]           m_chan;
    logic [DW-1:0]           m_din;
    logic [DW-1:0]           m_dout;
    logic [3*CHANNELS-1:0]   m_status;
    logic                    m_irq_n;

    // Sound (Z80) side
    logic                    s_rd;
    logic                    s_wr;
    logic [CW-1:0]           s_chan;
    logic [DW-1:0]           s_din;
    logic [DW-1:0]           s_dout;
    logic [CHANNELS-1:0]     s_status;
    logic                    s_irq_n;

    modport master (
        output m_wr, m_rd, m_chan, m_din,
        input  m_dout, m_status, m_irq_n,
        output s_rd, s_wr, s_chan, s_din,
        input  s_dout, s_status, s_irq_n
    );

    modport slave (
        input  m_wr, m_rd, m_chan, m_din,
        output m_dout, m_status, m_irq_n,
        input  s_rd, s_wr, s_chan, s_din,
        output s_dout, s_status, s_irq_n
    );

endinterface
`default_nettype wire

// File: rtl/pgm_sound_mailbox_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : pgm_mailbox_fifo
//  Description : One downstream channel: DEPTH x DW FIFO with a hold register
//                that replays the last popped value on an empty pop, and a
//                full-push policy of overwrite-newest or drop.
//  Revision    : 1.0  initial release
// ============================================================================
module pgm_mailbox_fifo
    import pgm_snd_pkg::*;
#(
    parameter int DW        = 8,
    parameter int DEPTH     = 4,
    parameter int OVERWRITE = 1
) (
    input  wire logic          clk_i,
    input  wire logic          rst_i,
    input  wire logic          push_i,
    input  wire logic          pop_i,
    input  wire logic          clr_ovf_i,
    input  wire logic [DW-1:0] din_i,
    output logic [DW-1:0]      rd_data_o,
    output logic               nonempty_nxt_o,
    output logic               full_nxt_o,
    output logic               ovf_nxt_o
);

    localparam int               PW       = calc_ptrw(DEPTH);
    localparam int               CNTW     = calc_cntw(DEPTH);
    localparam logic [PW-1:0]    PTR_LAST = PW'(DEPTH - 1);
    localparam logic [CNTW-1:0]  CNT_FULL = CNTW'(DEPTH);

    logic [DW-1:0]   mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0] count_q,  count_d;
    logic [DW-1:0]   hold_q,   hold_d;
    logic            ovf_q,    ovf_d;

    logic            w_empty, w_full;
    logic            w_do_pop, w_do_push, w_do_ovr, w_set_ovf;
    logic [PW-1:0]   w_wr_prev;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [PW-1:0] ptr_dec(input logic [PW-1:0] p);
        return (p == '0) ? PTR_LAST : p - 1'b1;
    endfunction

    // Push/pop decisions and next-state values; a pop in the same cycle frees
    // the slot, so a full push alongside a pop is a normal write
    always_comb begin
        w_empty   = (count_q == '0);
        w_full    = (count_q == CNT_FULL);
        w_do_pop  = pop_i && !w_empty;
        w_do_push = push_i && (!w_full || w_do_pop);
        w_set_ovf = push_i && w_full && !w_do_pop;
        w_do_ovr  = w_set_ovf && (OVERWRITE != 0);
        w_wr_prev = ptr_dec(wr_ptr_q);

        rd_data_o = w_empty ? hold_q : mem_q[rd_ptr_q];

        wr_ptr_d  = w_do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d  = w_do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        hold_d    = w_do_pop  ? mem_q[rd_ptr_q]   : hold_q;

        count_d = count_q;
        if (w_do_push && !w_do_pop) begin
            count_d = count_q + 1'b1;
        end else if (w_do_pop && !w_do_push) begin
            count_d = count_q - 1'b1;
        end

        // A fresh overflow wins over a clear arriving in the same cycle
        ovf_d = ovf_q;
        if (w_set_ovf) begin
            ovf_d = 1'b1;
        end else if (clr_ovf_i) begin
            ovf_d = 1'b0;
        end

        nonempty_nxt_o = (count_d != '0);
        full_nxt_o     = (count_d == CNT_FULL);
        ovf_nxt_o      = ovf_d;
    end

    // Pointer, counter, hold and overflow state
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            hold_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            hold_q   <= hold_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage array; contents are only meaningful below count, so no reset
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (w_do_push) begin
                mem_q[wr_ptr_q] <= din_i;
            end else if (w_do_ovr) begin
                mem_q[w_wr_prev] <= din_i;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/pgm_sound_mailbox.sv
`default_nettype none
// ============================================================================
//  Module      : pgm_sound_mailbox
//  Description : Multi-channel 68k <-> Z80 mailbox. Downstream FIFO per
//                channel, single-entry upstream reply latch per channel,
//                registered status flags and interrupt requests.
//  Revision    : 1.0  initial release
// ============================================================================
module pgm_sound_mailbox
    import pgm_snd_pkg::*;
#(
    parameter int                  CHANNELS  = 3,
    parameter int                  DW        = 8,
    parameter int                  DEPTH     = 4,
    parameter int                  OVERWRITE = 1,
    parameter logic [CHANNELS-1:0] IRQ_MASK  = {CHANNELS{1'b1}}
) (
    input  wire logic          fixed_20m_clk,
    input  wire logic          reset,
    pgm_sound_mailbox_if.slave mbx
);

    localparam int CW = calc_cw(CHANNELS);

    logic [CHANNELS-1:0]   w_m_sel, w_s_sel;
    logic [CHANNELS-1:0]   w_push, w_pop, w_wlatch, w_rlatch;
    logic [DW-1:0]         w_fifo_rd [CHANNELS];
    logic [CHANNELS-1:0]   w_nonempty_d, w_full_d, w_ovf_d;

    logic [DW-1:0]         latch_q [CHANNELS];
    logic [CHANNELS-1:0]   pend_q, pend_d;
    logic [DW-1:0]         m_dout_q, m_dout_d;
    logic [DW-1:0]         s_dout_q, s_dout_d;
    logic [3*CHANNELS-1:0] m_status_q, m_status_d;
    logic [CHANNELS-1:0]   s_status_q, s_status_d;
    logic                  m_irq_n_q, s_irq_n_q;

    // Channel decode; an out-of-range select matches nothing and so is inert
    always_comb begin
        w_m_sel = '0;
        w_s_sel = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            w_m_sel[i] = (mbx.m_chan == CW'(i));
            w_s_sel[i] = (mbx.s_chan == CW'(i));
        end
    end

    assign w_push   = w_m_sel & {CHANNELS{mbx.m_wr}};
    assign w_rlatch = w_m_sel & {CHANNELS{mbx.m_rd}};
    assign w_pop    = w_s_sel & {CHANNELS{mbx.s_rd}};
    assign w_wlatch = w_s_sel & {CHANNELS{mbx.s_wr}};

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
        pgm_mailbox_fifo #(
            .DW        (DW),
            .DEPTH     (DEPTH),
            .OVERWRITE (OVERWRITE)
        ) u_fifo (
            .clk_i          (fixed_20m_clk),
            .rst_i          (reset),
            .push_i         (w_push[gi]),
            .pop_i          (w_pop[gi]),
            .clr_ovf_i      (w_rlatch[gi]),
            .din_i          (mbx.m_din),
            .rd_data_o      (w_fifo_rd[gi]),
            .nonempty_nxt_o (w_nonempty_d[gi]),
            .full_nxt_o     (w_full_d[gi]),
            .ovf_nxt_o      (w_ovf_d[gi])
        );
    end

    // Read-data muxes and pending flags; the main read sees the latch value
    // from before any same-cycle sound write, and that write keeps pending set
    always_comb begin
        m_dout_d = m_dout_q;
        s_dout_d = s_dout_q;
        for (int i = 0; i < CHANNELS; i++) begin
            if (w_rlatch[i]) begin
                m_dout_d = latch_q[i];
            end
            if (w_pop[i]) begin
                s_dout_d = w_fifo_rd[i];
            end
        end
        pend_d = (pend_q & ~w_rlatch) | w_wlatch;
    end

    // Status vectors assembled from next-state flags so they lag by one edge
    always_comb begin
        m_status_d = '0;
        s_status_d = w_nonempty_d;
        for (int i = 0; i < CHANNELS; i++) begin
            m_status_d[3*i + OVF_BIT]  = w_ovf_d[i];
            m_status_d[3*i + FULL_BIT] = w_full_d[i];
            m_status_d[3*i + PEND_BIT] = pend_d[i];
        end
    end

    // Upstream latches, read data, status and interrupt registers
    always_ff @(posedge fixed_20m_clk) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                latch_q[i] <= '0;
            end
            pend_q     <= '0;
            m_dout_q   <= '0;
            s_dout_q   <= '0;
            m_status_q <= '0;
            s_status_q <= '0;
            m_irq_n_q  <= 1'b1;
            s_irq_n_q  <= 1'b1;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (w_wlatch[i]) begin
                    latch_q[i] <= mbx.s_din;
                end
            end
            pend_q     <= pend_d;
            m_dout_q   <= m_dout_d;
            s_dout_q   <= s_dout_d;
            m_status_q <= m_status_d;
            s_status_q <= s_status_d;
            m_irq_n_q  <= ~|pend_d;
            s_irq_n_q  <= ~|(w_nonempty_d & IRQ_MASK);
        end
    end

    assign mbx.m_dout   = m_dout_q;
    assign mbx.m_status = m_status_q;
    assign mbx.m_irq_n  = m_irq_n_q;
    assign mbx.s_dout   = s_dout_q;
    assign mbx.s_status = s_status_q;
    assign mbx.s_irq_n  = s_irq_n_q;

endmodule
`default_nettype wire

// File: tb/tb_pgm_sound_mailbox.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pgm_sound_mailbox
//  Description : Bench for two mailbox instances fed identical stimulus:
//                inst A overwrites on full with all IRQs enabled, inst B drops
//                on full with channel 2 masked. Both are compared every cycle
//                against a queue-based mailbox model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pgm_sound_mailbox;

    localparam int          DEPTH    = 4;
    localparam logic [1:0]  OVW_BITS = 2'b01;             // bit n: inst n overwrites
    localparam logic [5:0]  MASKS    = {3'b011, 3'b111};  // [2:0] inst A, [5:3] inst B

    logic       clk;
    logic       reset;
    logic       m_wr, m_rd, s_rd, s_wr;
    logic [1:0] m_chan, s_chan;
    logic [7:0] m_din, s_din;

    int n_chk;
    int n_bad;

    pgm_sound_mailbox_if #(.CHANNELS(3), .DW(8)) if_a ();
    pgm_sound_mailbox_if #(.CHANNELS(3), .DW(8)) if_b ();

    assign if_a.m_wr = m_wr;   assign if_b.m_wr = m_wr;
    assign if_a.m_rd = m_rd;   assign if_b.m_rd = m_rd;
    assign if_a.m_chan = m_chan; assign if_b.m_chan = m_chan;
    assign if_a.m_din = m_din; assign if_b.m_din = m_din;
    assign if_a.s_rd = s_rd;   assign if_b.s_rd = s_rd;
    assign if_a.s_wr = s_wr;   assign if_b.s_wr = s_wr;
    assign if_a.s_chan = s_chan; assign if_b.s_chan = s_chan;
    assign if_a.s_din = s_din; assign if_b.s_din = s_din;

    pgm_sound_mailbox #(
        .CHANNELS(3), .DW(8), .DEPTH(DEPTH), .OVERWRITE(1), .IRQ_MASK(3'b111)
    ) dut_a (
        .fixed_20m_clk (clk),
        .reset         (reset),
        .mbx           (if_a)
    );

    pgm_sound_mailbox #(
        .CHANNELS(3), .DW(8), .DEPTH(DEPTH), .OVERWRITE(0), .IRQ_MASK(3'b011)
    ) dut_b (
        .fixed_20m_clk (clk),
        .reset         (reset),
        .mbx           (if_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model (index = inst*3 + channel) -----------
    logic [7:0] mq [6][$];
    logic [7:0] hold_m [6];
    logic [7:0] latch_m [6];
    bit         ovf_m [6];
    bit         pend_m [6];
    logic [7:0] e_mdout [2];
    logic [7:0] e_sdout [2];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 6; k++) begin
            mq[k].delete();
            hold_m[k]  = '0;
            latch_m[k] = '0;
            ovf_m[k]   = 1'b0;
            pend_m[k]  = 1'b0;
        end
        for (int n = 0; n < 2; n++) begin
            e_mdout[n] = '0;
            e_sdout[n] = '0;
        end
    endtask

    // One clock edge of mailbox behaviour, evaluated from the pre-edge state
    task automatic model_step();
        int  bm, bs;
        bit  m_ok, s_ok, was_full, popped;
        if (reset) begin
            model_reset();
            return;
        end
        for (int n = 0; n < 2; n++) begin
            m_ok     = (m_chan < 2'd3);
            s_ok     = (s_chan < 2'd3);
            bm       = n * 3 + int'(m_chan);
            bs       = n * 3 + int'(s_chan);
            was_full = m_ok && (mq[bm].size() == DEPTH);
            popped   = 1'b0;
            if (m_rd && m_ok) begin
                e_mdout[n] = latch_m[bm];
                pend_m[bm] = 1'b0;
                ovf_m[bm]  = 1'b0;
            end
            if (s_rd && s_ok) begin
                if (mq[bs].size() != 0) begin
                    hold_m[bs] = mq[bs].pop_front();
                    popped     = m_ok && (bs == bm);
                end
                e_sdout[n] = hold_m[bs];
            end
            if (m_wr && m_ok) begin
                if (!was_full || popped) begin
                    mq[bm].push_back(m_din);
                end else begin
                    ovf_m[bm] = 1'b1;
                    if (OVW_BITS[n]) mq[bm][DEPTH-1] = m_din;
                end
            end
            if (s_wr && s_ok) begin
                latch_m[bs] = s_din;
                pend_m[bs]  = 1'b1;
            end
        end
    endtask

    task automatic check_all();
        logic [8:0] em;
        logic [2:0] es;
        logic [2:0] ep;
        logic [2:0] msk;
        for (int n = 0; n < 2; n++) begin
            em  = '0;
            es  = '0;
            ep  = '0;
            msk = MASKS[n*3 +: 3];
            for (int c = 0; c < 3; c++) begin
                em[3*c + 2] = ovf_m[n*3 + c];
                em[3*c + 1] = (mq[n*3 + c].size() == DEPTH);
                em[3*c + 0] = pend_m[n*3 + c];
                ep[c]       = pend_m[n*3 + c];
                es[c]       = (mq[n*3 + c].size() != 0);
            end
            check_eq($sformatf("m_dout[%0d]", n),   (n == 0) ? if_a.m_dout   : if_b.m_dout,   e_mdout[n]);
            check_eq($sformatf("s_dout[%0d]", n),   (n == 0) ? if_a.s_dout   : if_b.s_dout,   e_sdout[n]);
            check_eq($sformatf("m_status[%0d]", n), (n == 0) ? if_a.m_status : if_b.m_status, em);
            check_eq($sformatf("s_status[%0d]", n), (n == 0) ? if_a.s_status : if_b.s_status, es);
            check_eq($sformatf("m_irq_n[%0d]", n),  (n == 0) ? if_a.m_irq_n  : if_b.m_irq_n,  ~|ep);
            check_eq($sformatf("s_irq_n[%0d]", n),  (n == 0) ? if_a.s_irq_n  : if_b.s_irq_n,  ~|(es & msk));
        end
    endtask

    // Advance one edge, update the model, then sample the DUTs off the edge
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic idle();
        m_wr = 0; m_rd = 0; s_rd = 0; s_wr = 0;
    endtask

    // Apply one cycle of strobes then return to idle
    task automatic op(input bit mw, input bit mr, input logic [1:0] mc, input logic [7:0] md,
                      input bit sr, input bit sw, input logic [1:0] sc, input logic [7:0] sd);
        m_wr = mw; m_rd = mr; m_chan = mc; m_din = md;
        s_rd = sr; s_wr = sw; s_chan = sc; s_din = sd;
        tick();
        idle();
    endtask

    logic [7:0] exp_a [5];
    logic [7:0] exp_b [5];

    initial begin
        n_chk = 0;
        n_bad = 0;
        idle();
        m_chan = 0; s_chan = 0; m_din = 0; s_din = 0;
        reset = 1'b1;
        tick();
        tick();
        check_eq("rst_m_irq_n", if_a.m_irq_n, 1);
        check_eq("rst_s_irq_n", if_a.s_irq_n, 1);
        reset = 1'b0;
        tick();

        // Single write then read on channel 1
        op(1, 0, 2'd1, 8'h5A, 0, 0, 2'd0, 8'h00);
        check_eq("ch1_nonempty", if_a.s_status[1], 1);
        check_eq("ch1_irq", if_a.s_irq_n, 0);
        op(0, 0, 2'd0, 8'h00, 1, 0, 2'd1, 8'h00);
        check_eq("ch1_pop", if_a.s_dout, 8'h5A);
        check_eq("ch1_empty", if_a.s_status[1], 0);
        check_eq("ch1_irq_off", if_a.s_irq_n, 1);

        // Five pushes into a 4-deep FIFO, five pops
        for (int i = 1; i <= 5; i++) op(1, 0, 2'd0, 8'(i), 0, 0, 2'd0, 8'h00);
        check_eq("ovf_a_set", if_a.m_status[2], 1);
        check_eq("ovf_b_set", if_b.m_status[2], 1);
        exp_a = '{8'h01, 8'h02, 8'h03, 8'h05, 8'h05};
        exp_b = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
        for (int i = 0; i < 5; i++) begin
            op(0, 0, 2'd0, 8'h00, 1, 0, 2'd0, 8'h00);
            check_eq($sformatf("ovw_pop%0d", i), if_a.s_dout, exp_a[i]);
            check_eq($sformatf("drop_pop%0d", i), if_b.s_dout, exp_b[i]);
        end
        check_eq("ovf_a_sticky", if_a.m_status[2], 1);
        check_eq("ovf_b_sticky", if_b.m_status[2], 1);
        op(0, 1, 2'd0, 8'h00, 0, 0, 2'd0, 8'h00);
        check_eq("ovf_a_clr", if_a.m_status[2], 0);
        check_eq("ovf_b_clr", if_b.m_status[2], 0);

        // Upstream latch with coincident write and read on channel 2
        op(0, 0, 2'd0, 8'h00, 0, 1, 2'd2, 8'h11);
        check_eq("up_irq", if_a.m_irq_n, 0);
        op(0, 1, 2'd2, 8'h00, 1, 1, 2'd2, 8'hA3);
        check_eq("up_old", if_a.m_dout, 8'h11);
        check_eq("up_pend", if_a.m_status[6], 1);
        check_eq("up_irq_hold", if_a.m_irq_n, 0);
        op(0, 1, 2'd2, 8'h00, 0, 0, 2'd0, 8'h00);
        check_eq("up_new", if_a.m_dout, 8'hA3);
        check_eq("up_irq_off", if_a.m_irq_n, 1);

        // IRQ mask on inst B: channel 2 masked, channel 0 enabled
        op(1, 0, 2'd2, 8'h22, 0, 0, 2'd0, 8'h00);
        check_eq("mask_ch2", if_b.s_irq_n, 1);
        op(1, 0, 2'd0, 8'h33, 0, 0, 2'd0, 8'h00);
        check_eq("mask_ch0", if_b.s_irq_n, 0);
        op(0, 0, 2'd0, 8'h00, 1, 0, 2'd2, 8'h00);
        op(0, 0, 2'd0, 8'h00, 1, 0, 2'd0, 8'h00);

        // Full FIFO with simultaneous push and pop
        for (int i = 0; i < 4; i++) op(1, 0, 2'd1, 8'(8'h10 + i), 0, 0, 2'd0, 8'h00);
        op(1, 0, 2'd1, 8'h77, 1, 0, 2'd1, 8'h00);
        check_eq("full_pp_dout", if_a.s_dout, 8'h10);
        check_eq("full_pp_full", if_a.m_status[4], 1);
        check_eq("full_pp_ovf", if_a.m_status[5], 0);
        for (int i = 0; i < 4; i++) op(0, 0, 2'd0, 8'h00, 1, 0, 2'd1, 8'h00);
        check_eq("full_pp_last", if_a.s_dout, 8'h77);

        // Reset in the middle of a burst with a coincident write
        op(1, 0, 2'd0, 8'h44, 0, 1, 2'd0, 8'h99);
        op(1, 0, 2'd1, 8'h55, 1, 0, 2'd0, 8'h00);
        reset = 1'b1;
        op(1, 0, 2'd2, 8'h66, 0, 0, 2'd0, 8'h00);
        reset = 1'b0;
        check_eq("mrst_sstat", if_a.s_status, 0);
        check_eq("mrst_mstat", if_a.m_status, 0);
        check_eq("mrst_mirq", if_a.m_irq_n, 1);
        check_eq("mrst_sdout", if_a.s_dout, 0);
        op(0, 0, 2'd0, 8'h00, 1, 0, 2'd2, 8'h00);
        check_eq("mrst_not_stored", if_a.s_dout, 0);

        // Randomized traffic, including out-of-range channels and resets
        for (int i = 0; i < 800; i++) begin
            m_wr   = ($urandom_range(0, 2) == 0);
            m_rd   = ($urandom_range(0, 3) == 0);
            s_rd   = ($urandom_range(0, 2) == 0);
            s_wr   = ($urandom_range(0, 3) == 0);
            m_chan = 2'($urandom_range(0, 3));
            s_chan = ($urandom_range(0, 1) == 0) ? m_chan : 2'($urandom_range(0, 3));
            m_din  = 8'($urandom);
            s_din  = 8'($urandom);
            reset  = ($urandom_range(0, 99) == 0);
            tick();
        end
        reset = 1'b0;
        idle();
        tick();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pgm_sound_mailbox.md
Name: pgm_sound_mailbox

Overview:
- Parametrised successor to the fixed main-CPU/sound-CPU latch trio (latch1/latch2/latch3 at C00002/4/C).
- Provides CHANNELS bidirectional channels between the 68k (main) and the Z80 (sound) side:
  - a DEPTH-entry downstream FIFO (main->sound) per channel;
  - a single-entry upstream reply latch (sound->main) per channel.
- Generates interrupt requests and status flags that the old latches lacked.
- Sits between the address decoders and the CPU data muxes; bus decoding stays outside the block.

Parameters:
- CHANNELS, 3: number of mailbox channels (1..8).
- DW, 8: data width per entry.
- DEPTH, 4: downstream FIFO depth per channel (1..16). DEPTH=1 gives classic latch behaviour.
- OVERWRITE, 1: 1 = a push into a full FIFO replaces the newest entry; 0 = the push is dropped and overflow is set.
- IRQ_MASK, 3'b111: per-channel enable for s_irq_n.

Ports:
- fixed_20m_clk  in  1  sole clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- m_wr  in  1  one-cycle strobe: push m_din into the downstream FIFO of channel m_chan.
- m_rd  in  1  one-cycle strobe: read the upstream latch of m_chan and clear its pending flag.
- m_chan  in  CW  channel select, where CW = max(1, $clog2(CHANNELS)).
- m_din  in  DW  write data.
- m_dout  out  DW  registered upstream read data.
- m_status  out  3*CHANNELS  per channel {overflow, down_full, up_pending}.
- m_irq_n  out  1  low while any up_pending is set.
- s_rd  in  1  one-cycle strobe: pop the downstream FIFO of s_chan.
- s_wr  in  1  one-cycle strobe: write s_din to the upstream latch of s_chan.
- s_chan  in  CW  channel select.
- s_din  in  DW  write data.
- s_dout  out  DW  registered downstream read data.
- s_status  out  CHANNELS  per channel down_nonempty.
- s_irq_n  out  1  low while any channel with IRQ_MASK=1 is non-empty.

Behaviour:
- Reset values:
  - All FIFOs empty (pointers and count = 0).
  - Hold registers, m_dout, s_dout, upstream latches = 0.
  - up_pending and overflow = 0.
  - m_irq_n = s_irq_n = 1.
- Strobes:
  - Single-cycle pulses; a held-high strobe acts on every cycle.
  - Any strobe whose channel is >= CHANNELS is ignored and has no side effects.
- Downstream FIFO, per channel:
  - wr_ptr, rd_ptr, count; pointers wrap modulo DEPTH.
  - count is $clog2(DEPTH+1) bits wide.
- Pop (s_rd):
  - s_dout <= head entry, registered, valid the cycle after the strobe.
  - rd_ptr advances and count decrements.
  - The popped value is also copied into the per-channel hold register.
- Pop when empty: s_dout <= hold register (last popped value); state is unchanged. This preserves the re-read semantics of the old latches.
- Push (m_wr) when not full: write at wr_ptr, advance wr_ptr, increment count.
- Push when full:
  - OVERWRITE=1: overwrite entry (wr_ptr-1); count unchanged.
  - OVERWRITE=0: drop the data and set the sticky overflow flag.
  - In both modes overflow is set.
  - overflow clears only on reset or on m_rd of that channel.
- Push and pop on the same channel in the same cycle:
  - Non-empty: both take effect; count unchanged. Full is not treated as overflow.
  - Empty: push lands, pop returns the hold value, count becomes 1.
- Upstream latch (s_wr): latch <= s_din, up_pending <= 1.
- Upstream read (m_rd): m_dout <= latch (registered, 1-cycle latency), up_pending <= 0, overflow <= 0.
- s_wr and m_rd on the same channel in the same cycle: m_dout gets the OLD latch value; latch takes the new value; up_pending stays 1.
- Main-side writes (m_wr) and main-side reads (m_rd) act on independent structures; both may strobe together.
- Interrupts:
  - s_irq_n = ~|(nonempty & IRQ_MASK).
  - m_irq_n = ~|up_pending.
  - Both are registered; they update 1 cycle after the causing event.
- Status outputs are registered, with the same 1-cycle lag as the interrupts.
- Reset asserted mid-operation clears everything in the same edge; strobes coincident with reset are discarded.

Decomposition:
- Shared package pgm_snd_pkg holds:
  - localparam functions for CW and the count width;
  - the status bit-index constants OVF_BIT=2, FULL_BIT=1, PEND_BIT=0.
- One sub-module, pgm_mailbox_fifo: a single-channel DEPTH x DW FIFO with hold register and overwrite/drop policy. It is instantiated CHANNELS times in a generate loop.
- The top level owns the upstream latches, channel demux, output muxes and interrupt reduction.

Test Plan:
- Reset, then m_wr ch1 data 0x5A, then s_rd ch1:
  - s_status[1]=1 and s_irq_n=0 one cycle after the write;
  - s_dout=0x5A the cycle after s_rd;
  - s_status[1]=0 and s_irq_n=1 thereafter.
- DEPTH=4, OVERWRITE=1: push 0x01..0x05 into ch0, then pop 5 times:
  - pops return 0x01, 0x02, 0x03, 0x05, 0x05 (the fifth pop is on empty and returns the hold value);
  - overflow=1 until an m_rd on ch0.
- OVERWRITE=0, same stimulus:
  - pops return 0x01, 0x02, 0x03, 0x04, 0x04;
  - overflow is sticky and clears on m_rd ch0.
- s_wr ch2 0xA3 with m_rd ch2 in the same cycle (latch previously 0x11):
  - m_dout=0x11;
  - up_pending[2] stays 1 and m_irq_n=0;
  - a following m_rd gives 0xA3 and then m_irq_n=1.
- IRQ_MASK=3'b011: push into ch2 only, then into ch0:
  - s_irq_n stays 1 after the ch2 push;
  - s_irq_n goes 0 after the ch0 push.
- Full FIFO (4 entries) with simultaneous m_wr 0x77 and s_rd:
  - s_dout is the oldest entry;
  - count stays 4 and no overflow;
  - 0x77 is popped last.
- Reset asserted during a burst:
  - all status, IRQs and dout return to reset values;
  - a coincident m_wr is not stored.
